// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the memory-stage data port.
// Accepts one load/store per valid/ready handshake and waits LATENCY edges.
// It then performs an RV32 byte/half/word access on a little-endian byte array
// and pulses respValid for one cycle. Byte indices wrap modulo 2**ADDR_WIDTH.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses are flagged with respErr and leave the array untouched.
// When it is undefined, they are performed byte-wise and respErr stays 0.
//
// state | meaning
// IDLE  | reqReady=1, waiting for a request handshake
// BUSY  | request captured, counting down to the response edge
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [DATA_WIDTH-1:0] reqAddr,
  input  logic [DATA_WIDTH-1:0] reqWdata,
  input  logic                  reqWe,
  input  logic [2:0]            reqCtrl,
  output logic                  respValid,
  output logic [DATA_WIDTH-1:0] respRdata,
  output logic                  respErr,
  output logic                  busy
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam int MEM_BYTES = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic [7:0]            mem [MEM_BYTES];
  logic [ADDR_WIDTH-1:0] byte_addr [4];
  logic [7:0]            rd_byte [4];
  logic                  is_byte;
  logic                  is_half;
  logic                  misaligned;
  logic                  do_access;
  logic [3:0]            byte_we;
  logic [DATA_WIDTH-1:0] load_data;

  // Address bits above the array size are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^reqAddr[DATA_WIDTH-1:ADDR_WIDTH];

  // Access size: stores treat every code other than SB/SH as a word,
  // loads use the low two funct3 bits (bit 2 only selects zero-extension).
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    if (we_q) begin
      is_byte = (ctrl_q == 3'b000);
      is_half = (ctrl_q == 3'b001);
    end else begin
      is_byte = (ctrl_q[1:0] == 2'b00);
      is_half = (ctrl_q[1:0] == 2'b01);
    end
  end

  // Four consecutive byte lanes starting at the captured address, with wrap.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      byte_addr[i] = addr_q + ADDR_WIDTH'(i);
      rd_byte[i]   = mem[byte_addr[i]];
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = is_byte ? 1'b0 :
                      is_half ? addr_q[0] :
                                (addr_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Load result assembly with sign or zero extension.
  always_comb begin
    load_data = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
    if (is_byte) begin
      load_data = {{(DATA_WIDTH-8){~ctrl_q[2] & rd_byte[0][7]}}, rd_byte[0]};
    end else if (is_half) begin
      load_data = {{(DATA_WIDTH-16){~ctrl_q[2] & rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
    end
  end

  // Byte write enables, only on the response edge of a legal store.
  always_comb begin
    byte_we = 4'b0000;
    if (do_access && we_q && !misaligned) begin
      if (is_byte)      byte_we = 4'b0001;
      else if (is_half) byte_we = 4'b0011;
      else              byte_we = 4'b1111;
    end
  end

  // Array write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_we[i]) mem[byte_addr[i]] <= wdata_q[8*i +: 8];
    end
  end

  // Next-state, request capture and response generation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    ctrl_d       = ctrl_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = 1'b0;
    do_access    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (reqValid) begin
          addr_d  = reqAddr[ADDR_WIDTH-1:0];
          wdata_d = reqWdata;
          we_d    = reqWe;
          ctrl_d  = reqCtrl;
          cnt_d   = CNT_INIT;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          do_access    = 1'b1;
          resp_valid_d = 1'b1;
          resp_err_d   = misaligned;
          resp_rdata_d = (we_q || misaligned) ? '0 : load_data;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      ctrl_q       <= 3'b000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      ctrl_q       <= ctrl_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign reqReady  = (state_q == ST_IDLE);
  assign busy      = ~reqReady;
  assign respValid = resp_valid_q;
  assign respRdata = resp_rdata_q;
  assign respErr   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: table of load/store vectors checked through
// a response scoreboard, plus hand sequences for back-to-back, LATENCY=1 and
// reset-while-busy behaviour.
module tb_data_mem_responder;

  localparam int LAT = 2;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we, resp_valid, resp_err, busy;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0]  req_ctrl;

  logic        req_valid1, req_ready1, req_we1, resp_valid1, resp_err1, busy1;
  logic [31:0] req_addr1, req_wdata1, resp_rdata1;
  logic [2:0]  req_ctrl1;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(req_valid), .reqReady(req_ready), .reqAddr(req_addr),
    .reqWdata(req_wdata), .reqWe(req_we), .reqCtrl(req_ctrl),
    .respValid(resp_valid), .respRdata(resp_rdata), .respErr(resp_err),
    .busy(busy)
  );

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .reqValid(req_valid1), .reqReady(req_ready1), .reqAddr(req_addr1),
    .reqWdata(req_wdata1), .reqWe(req_we1), .reqCtrl(req_ctrl1),
    .respValid(resp_valid1), .respRdata(resp_rdata1), .respErr(resp_err1),
    .busy(busy1)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int unsigned due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard on each respValid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mon_en) begin
      chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~req_ready});
      if (resp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_rdata"}, resp_rdata, e.rdata);
          chk({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
          chk({e.name, "_latency"}, cyc, e.due);
        end
      end else begin
        chk("idle_resp_err", {31'd0, resp_err}, 32'd0);
        if (sb.size() != 0 && sb[0].due < cyc) begin
          e = sb.pop_front();
          chk({e.name, "_missing_resp"}, cyc, e.due);
        end
      end
    end
  end

  // Issues one request when ready and waits (bounded) for its response.
  task automatic apply(input vec_t v);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({v.name, "_ready_timeout"}, 32'd1, 32'd0);
    req_valid = 1'b1;
    req_we    = v.we;
    req_ctrl  = v.ctrl;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    sb.push_back('{v.name, v.rdata, v.err, cyc + 1 + LAT});
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({v.name, "_resp_timeout"}, 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [2:0] ctrl,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err);
    vec_t v;
    v.name = name; v.we = we; v.ctrl = ctrl; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  initial begin
    int prev_acc;
    int n_acc;
    int n;
    bit exp_b;

    req_valid = 0; req_we = 0; req_ctrl = 0; req_addr = 0; req_wdata = 0;
    req_valid1 = 0; req_we1 = 0; req_ctrl1 = 0; req_addr1 = 0; req_wdata1 = 0;

    tbl.push_back(mk("sw_deadbeef", 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0));
    tbl.push_back(mk("lw_100",      0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0));
    tbl.push_back(mk("lb_103",      0, 3'b000, 32'h103, 32'h0, 32'hFFFFFFDE, 0));
    tbl.push_back(mk("lbu_103",     0, 3'b100, 32'h103, 32'h0, 32'h000000DE, 0));
    tbl.push_back(mk("lh_102",      0, 3'b001, 32'h102, 32'h0, 32'hFFFFDEAD, 0));
    tbl.push_back(mk("lhu_102",     0, 3'b101, 32'h102, 32'h0, 32'h0000DEAD, 0));
    tbl.push_back(mk("sb_101",      1, 3'b000, 32'h101, 32'h12345655, 32'h0, 0));
    tbl.push_back(mk("lw_100_sb",   0, 3'b010, 32'h100, 32'h0, 32'hDEAD55EF, 0));
    tbl.push_back(mk("sw_zero_0",   1, 3'b010, 32'h0, 32'h0, 32'h0, 0));
    tbl.push_back(mk("sh_wrap",     1, 3'b001, 32'h1FFFF, 32'h0000BEEF, 32'h0, TRAP));
    tbl.push_back(mk("lbu_0_wrap",  0, 3'b100, 32'hFFFE0000, 32'h0,
                     TRAP ? 32'h0 : 32'h000000BE, 0));
    tbl.push_back(mk("sw_104",      1, 3'b010, 32'h104, 32'h87654321, 32'h0, 0));
    tbl.push_back(mk("lw_102_mis",  0, 3'b010, 32'h102, 32'h0,
                     TRAP ? 32'h0 : 32'h4321DEAD, TRAP));
    tbl.push_back(mk("lw_100_again", 0, 3'b010, 32'h100, 32'h0, 32'hDEAD55EF, 0));
    tbl.push_back(mk("lhu_106",     0, 3'b101, 32'h106, 32'h0, 32'h00008765, 0));
    tbl.push_back(mk("lh_106",      0, 3'b001, 32'h106, 32'h0, 32'hFFFF8765, 0));
    tbl.push_back(mk("lw011_104",   0, 3'b011, 32'h104, 32'h0, 32'h87654321, 0));
    tbl.push_back(mk("lw110_104",   0, 3'b110, 32'h104, 32'h0, 32'h87654321, 0));
    tbl.push_back(mk("s011_108",    1, 3'b011, 32'h108, 32'hA5A5C3C3, 32'h0, 0));
    tbl.push_back(mk("lw_108",      0, 3'b111, 32'h108, 32'h0, 32'hA5A5C3C3, 0));
    tbl.push_back(mk("s100_10c",    1, 3'b100, 32'h10C, 32'h01020384, 32'h0, 0));
    tbl.push_back(mk("lw_10c",      0, 3'b010, 32'h10C, 32'h0, 32'h01020384, 0));
    tbl.push_back(mk("lb_10c",      0, 3'b000, 32'h10C, 32'h0, 32'hFFFFFF84, 0));

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) apply(tbl[i]);

    // reqValid held high: one accept per LATENCY+1 cycles.
    req_we = 0; req_ctrl = 3'b010; req_addr = 32'h100; req_wdata = 0;
    req_valid = 1'b1;
    prev_acc = -1;
    n_acc = 0;
    for (int i = 0; i < 15; i++) begin
      if (req_ready === 1'b1) begin
        sb.push_back('{"b2b_lw", 32'hDEAD55EF, 1'b0, cyc + 1 + LAT});
        if (prev_acc >= 0) chk("b2b_spacing", cyc + 1 - prev_acc, LAT + 1);
        prev_acc = int'(cyc) + 1;
        n_acc++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_accepts", n_acc, 32'd5);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("b2b_resp_timeout", 32'd1, 32'd0);
      sb.delete();
    end

    // LATENCY=1 instance with reqValid held: accepts every second cycle.
    req_we1 = 1; req_ctrl1 = 3'b010; req_addr1 = 32'h200; req_wdata1 = 32'h0;
    req_valid1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_b = (i % 2) == 1;
      chk("lat1_ready", {31'd0, req_ready1}, {31'd0, exp_b});
      chk("lat1_resp_valid", {31'd0, resp_valid1}, {31'd0, exp_b});
    end
    req_valid1 = 1'b0;
    @(negedge clk);

    // Reset one cycle after accepting a store: no response, no write.
    req_we = 1; req_ctrl = 3'b010; req_addr = 32'h100; req_wdata = 32'h0;
    req_valid = 1'b1;
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    apply(mk("lw_after_rst", 0, 3'b010, 32'h100, 32'h0, 32'hDEAD55EF, 0));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
